// File: rtl/rotate_controller.sv
// rtl/rotate_controller.sv - rho-rotation line sequencer: issues lane lookups, assembles rotated words, hands them downstream
// Optional feature macro: ROTATE_CYCLE_CNT_EN (adds the cycle_cnt output and counter)
module rotate_controller #(
    parameter int N     = 25,
    parameter int LINES = 64,
    parameter int IDX_W = 5,
    parameter int LN_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ROTATE_CYCLE_CNT_EN
    output logic [15:0]      cycle_cnt,
`endif
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ld_curr_fr,
    output logic             ld_des_fr,
    output logic [LN_W-1:0]  line_number,
    output logic [IDX_W-1:0] index,
    input  logic [N-1:0]     pout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_word,
    output logic [LN_W-1:0]  out_line
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t           state;
    logic             cap_en;
    logic [IDX_W-1:0] cap_idx;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [LN_W-1:0]  LAST_LINE = LN_W'(LINES);

    // The reader's current-frame path is not used by this block.
    assign ld_curr_fr = 1'b0;

    // Sequencer FSM plus the one-cycle-delayed capture of the reader's registered pout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ld_des_fr   <= 1'b0;
            line_number <= '0;
            index       <= '0;
            cap_en      <= 1'b0;
            cap_idx     <= '0;
            out_valid   <= 1'b0;
            out_word    <= '0;
            out_line    <= '0;
        end else begin
            // pout answers the lookup issued on the previous cycle, so the
            // capture pointer trails the issued index by exactly one cycle.
            cap_en  <= ld_des_fr;
            cap_idx <= index;

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= S_RUN;
                        busy        <= 1'b1;
                        line_number <= LN_W'(1);
                        index       <= '0;
                        ld_des_fr   <= 1'b1;
                        out_word    <= '0;
                    end
                end

                S_RUN: begin
                    if (index == LAST_IDX) begin
                        state     <= S_DRAIN;
                        ld_des_fr <= 1'b0;
                    end else begin
                        index <= index + IDX_W'(1);
                    end
                end

                // Last lane is captured on this edge, so the word is complete
                // exactly when out_valid rises.
                S_DRAIN: begin
                    state     <= S_OUT;
                    out_valid <= 1'b1;
                    out_line  <= line_number;
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (line_number == LAST_LINE) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state       <= S_RUN;
                            line_number <= line_number + LN_W'(1);
                            index       <= '0;
                            ld_des_fr   <= 1'b1;
                            out_word    <= '0;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    ld_des_fr <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase

            // Capture is idle whenever out_word is being cleared, so this
            // never collides with the clear in S_OUT.
            if (cap_en) begin
                out_word[cap_idx] <= pout[cap_idx];
            end
        end
    end

`ifdef ROTATE_CYCLE_CNT_EN
    // Pass-length counter; the accepted-start cycle is counted as the first cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            cycle_cnt <= 16'd1;
        end else if (busy) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rotate_controller.sv
// tb/tb_rotate_controller.sv - directed self-checking bench for rotate_controller
module tb_rotate_controller;

    localparam int N     = 25;
    localparam int LINES = 64;
    localparam int IDX_W = 5;
    localparam int LN_W  = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             ld_curr_fr;
    logic             ld_des_fr;
    logic [LN_W-1:0]  line_number;
    logic [IDX_W-1:0] index;
    logic [N-1:0]     pout = '0;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_word;
    logic [LN_W-1:0]  out_line;
`ifdef ROTATE_CYCLE_CNT_EN
    logic [15:0]      cycle_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    localparam int OFF [N] = '{21, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 0,
                               25, 39, 41, 45, 15, 43, 8, 18, 2, 61, 56, 14};

    rotate_controller #(.N(N), .LINES(LINES), .IDX_W(IDX_W), .LN_W(LN_W)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef ROTATE_CYCLE_CNT_EN
        .cycle_cnt   (cycle_cnt),
`endif
        .start       (start),
        .busy        (busy),
        .done        (done),
        .ld_curr_fr  (ld_curr_fr),
        .ld_des_fr   (ld_des_fr),
        .line_number (line_number),
        .index       (index),
        .pout        (pout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_line    (out_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // Input line z (1..64), bit i
    function automatic logic in_bit(input int z, input int i);
        logic [7:0] v;
        v = 8'(z + i);
        return ^v;
    endfunction

    // Input line feeding output line L, lane i (mod-64 wrap, 0 maps to 64)
    function automatic int src_line(input int l, input int i);
        int z;
        z = (((l - OFF[i]) % 64) + 64) % 64;
        if (z == 0) z = 64;
        return z;
    endfunction

    function automatic logic [N-1:0] exp_word(input int l);
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) w[i] = in_bit(src_line(l, i), i);
        return w;
    endfunction

    // Reader model: registered pout, only the looked-up lane is meaningful
    always @(posedge clk) begin
        if (ld_des_fr) begin
            logic [N-1:0] r;
            r = N'($urandom);
            if (int'(index) < N) r[index] = in_bit(src_line(int'(line_number), int'(index)), int'(index));
            pout <= r;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ld"}, 64'({ld_des_fr, ld_curr_fr}), 64'd0);
        check({tag, "_line_number"}, 64'(line_number), 64'd0);
        check({tag, "_index"}, 64'(index), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_word"}, 64'(out_word), 64'd0);
        check({tag, "_out_line"}, 64'(out_line), 64'd0);
`ifdef ROTATE_CYCLE_CNT_EN
        check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
`endif
    endtask

    initial begin
        int c_start;
        int n;
        int done_base;
        logic bad;
        logic [N-1:0] held_word;
        logic [LN_W-1:0] held_line;

        // Reset held with start asserted
        rst = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_zero("reset");
        start = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_lookup", 64'(ld_des_fr), 64'd0);

        // Pass A: single-line latency then full pass with out_ready tied high
        c_start = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_lookup", 64'(ld_des_fr), 64'd1);
        check("first_line_number", 64'(line_number), 64'd1);
        check("first_index", 64'(index), 64'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'd26);
        check("line1_out_line", 64'(out_line), 64'd1);
        check("line1_bit12", 64'(out_word[12]), 64'(in_bit(1, 12)));
        check("line1_bit0", 64'(out_word[0]), 64'(in_bit(44, 0)));
        for (int l = 1; l <= LINES; l++) begin
            if (l > 1) wait_valid("passA_timeout");
            check("passA_out_line", 64'(out_line), 64'(l));
            check("passA_out_word", 64'(out_word), 64'(exp_word(l)));
            @(negedge clk);
        end
        check("passA_done", 64'(done), 64'd1);
        check("passA_busy_at_done", 64'(busy), 64'd0);
        check("passA_cycles", 64'(cyc - c_start), 64'd1729);
`ifdef ROTATE_CYCLE_CNT_EN
        check("passA_cycle_cnt", 64'(cycle_cnt), 64'd1729);
`endif
        @(negedge clk);
        check("passA_done_pulse", 64'(done), 64'd0);
        repeat (3) @(negedge clk);

        // Pass B: backpressure on line 5, stray start during line 30
        done_base = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int l = 1; l <= LINES; l++) begin
            if (l == 5) out_ready = 1'b0;
            if (l == 30) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_valid("passB_timeout");
            if (l == 5) begin
                held_word = out_word;
                held_line = out_line;
                bad = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (!out_valid || ld_des_fr || out_word !== held_word || out_line !== held_line) bad = 1'b1;
                end
                check("stall_stable", 64'(bad), 64'd0);
                out_ready = 1'b1;
            end
            check("passB_out_line", 64'(out_line), 64'(l));
            check("passB_out_word", 64'(out_word), 64'(exp_word(l)));
            @(negedge clk);
        end
        check("passB_done", 64'(done), 64'd1);
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid || busy || ld_des_fr) bad = 1'b1;
        end
        check("passB_quiet_after_done", 64'(bad), 64'd0);
        check("passB_done_count", 64'(done_cnt - done_base), 64'd1);

        // Pass C: reset during line 17 at index 9
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int l = 1; l <= 16; l++) begin
            wait_valid("passC_timeout");
            @(negedge clk);
        end
        n = 0;
        while (!(ld_des_fr && index == IDX_W'(9)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midpass_line_number", 64'(line_number), 64'd17);
        check("midpass_index", 64'(index), 64'd9);
        done_base = done_cnt;
        rst = 1'b0;
        #1;
        check_zero("midpass_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("midpass_no_done", 64'(done_cnt - done_base), 64'd0);
        check("midpass_idle", 64'({busy, ld_des_fr, out_valid}), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_line_number", 64'(line_number), 64'd1);
        wait_valid("restart_timeout");
        check("restart_out_line", 64'(out_line), 64'd1);
        check("restart_out_word", 64'(out_word), 64'(exp_word(1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
